// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of HI/LO.
// Multiply finishes MULT_CYCLES edges after acceptance. Divide is radix-2 restoring,
// one bit per edge, followed by one sign-fix cycle.
// Ports:
//   clk, reset             clock (rising edge) and asynchronous active-high reset
//   start, isDiv           valid mul/div in EX; 1 = DIV*, 0 = MULT*
//   isUnsigned             1 = MULTU/DIVU
//   opA, opB               rs / rt operands
//   hiloRead               MFHI/MFLO in EX
//   mtHi, mtLo, mtData     MTHI/MTLO write strobes and data
//   cancel                 flush; aborts any in-flight operation
//   hi, lo                 HI/LO registers
//   busy                   operation in flight
//   stall                  freeze IF..EX this cycle
//   done                   one-cycle pulse: HI/LO were updated by a mul/div at this edge
module hilo_muldiv_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             isDiv,
  input  logic             isUnsigned,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             hiloRead,
  input  logic             mtHi,
  input  logic             mtLo,
  input  logic [WIDTH-1:0] mtData,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int unsigned CntMax = (WIDTH > MULT_CYCLES) ? WIDTH : MULT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // a_q holds the multiplicand, or the dividend magnitude that becomes the quotient.
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              uns_q, uns_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;

  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH:0]     shifted, trial;
  logic               sign_a, sign_b;

  // Extending both operands to 2*WIDTH makes a plain truncated product correct for
  // both signed and unsigned forms.
  always_comb begin
    ext_a = uns_q ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
    ext_b = uns_q ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod  = ext_a * ext_b;
  end

  // Restoring step: trial[WIDTH] set means the subtraction went negative.
  always_comb begin
    shifted = {rem_q, a_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    uns_d     = uns_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sign_a    = ~isUnsigned & opA[WIDTH-1];
    sign_b    = ~isUnsigned & opB[WIDTH-1];

    unique case (state_q)
      StIdle: begin
        if (cancel) begin
          // Flush: nothing in EX commits, including MTHI/MTLO.
        end else if (mtHi || mtLo) begin
          if (mtHi) hi_d = mtData;
          if (mtLo) lo_d = mtData;
        end else if (start) begin
          uns_d     = isUnsigned;
          neg_quo_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          rem_d     = '0;
          cnt_d     = '0;
          if (isDiv) begin
            a_d     = sign_a ? -opA : opA;
            b_d     = sign_b ? -opB : opB;
            state_d = StDiv;
          end else begin
            a_d     = opA;
            b_d     = opB;
            state_d = StMul;
          end
        end
      end
      StMul: begin
        if (cnt_q == CntW'(MULT_CYCLES - 1)) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDiv: begin
        a_d   = {a_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        lo_d    = neg_quo_q ? -a_q : a_q;
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (cancel) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      uns_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      uns_q     <= uns_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != StIdle);
  assign stall = busy & (start | hiloRead | mtHi | mtLo);
  assign done  = done_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer: inputs driven and outputs sampled on the
// falling edge, so each rising edge sits between a drive and the next sample.
module tb_hilo_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         isDiv = 1'b0;
  logic         isUnsigned = 1'b0;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic         hiloRead = 1'b0;
  logic         mtHi = 1'b0;
  logic         mtLo = 1'b0;
  logic [W-1:0] mtData = '0;
  logic         cancel = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, stall, done;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_sequencer #(.WIDTH(W), .MULT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .isDiv(isDiv), .isUnsigned(isUnsigned),
    .opA(opA), .opB(opB), .hiloRead(hiloRead), .mtHi(mtHi), .mtLo(mtLo),
    .mtData(mtData), .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .stall(stall),
    .done(done)
  );

  always #5 clk = ~clk;

  // Issues one op, then counts falling edges until done; lat = edges from E0 to done,
  // busy_cnt = sampled cycles with busy high before done.
  task automatic run_op(input logic div, input logic uns, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; isDiv = div; isUnsigned = uns; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({hi, lo, busy, stall, done} !== '0) begin
      errors++;
      $display("FAIL reset: hi=%h lo=%h busy=%b stall=%b done=%b, required all zero",
               hi, lo, busy, stall, done);
    end
  endtask

  task automatic test_mult_signed();
    int lat, bc;
    run_op(1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3, lat, bc);
    checks++;
    if (lat != 4 || bc != 4) begin
      errors++; $display("FAIL mult_latency: lat=%0d busy=%0d, required 4/4", lat, bc);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA || busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_result: hi=%h lo=%h busy=%b, required ffffffff/fffffffa/0",
               hi, lo, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL mult_done_pulse: done=%b, required 0", done);
    end
  endtask

  task automatic test_multu();
    int lat, bc;
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checks++;
    if (lat != 4 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu: lat=%0d hi=%h lo=%h, required 4/fffffffe/00000001", lat, hi, lo);
    end
  endtask

  task automatic test_div(input string name, input logic uns, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_lo,
                          input logic [W-1:0] exp_hi);
    int lat, bc;
    run_op(1'b1, uns, a, b, lat, bc);
    checks++;
    // 32 iterations plus one sign-fix edge.
    if (lat != 33 || bc != 33 || lo !== exp_lo || hi !== exp_hi) begin
      errors++;
      $display("FAIL %s: lat=%0d busy=%0d lo=%h hi=%h, required 33/33 lo=%h hi=%h",
               name, lat, bc, lo, hi, exp_lo, exp_hi);
    end
  endtask

  task automatic test_stall_hilo();
    int n, cyc;
    bit gap;
    @(negedge clk);
    hiloRead = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL idle_stall: stall=%b, required 0", stall);
    end
    start = 1'b1; isDiv = 1'b1; isUnsigned = 1'b1; opA = 32'd50; opB = 32'd8;
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0; gap = 1'b0;
    while (!done && cyc < 100) begin
      if (stall) n++; else gap = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++;
    // MFHI waits through all DIV iterations and the fix cycle.
    if (n != 33 || gap) begin
      errors++; $display("FAIL stall_count: stalled=%0d gap=%b, required 33/0", n, gap);
    end
    checks++;
    if (stall !== 1'b0 || hi !== 32'd2 || lo !== 32'd6) begin
      errors++;
      $display("FAIL stall_release: stall=%b hi=%h lo=%h, required 0/2/6", stall, hi, lo);
    end
    hiloRead = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    start = 1'b1; isDiv = 1'b0; isUnsigned = 1'b1; opA = 32'd2; opB = 32'd3;
    @(negedge clk);
    opA = 32'd5; opB = 32'd7; isUnsigned = 1'b0;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL b2b_stall: stall=%b, required 1", stall);
    end
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != 4 || lo !== 32'd6 || stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: cyc=%0d lo=%h stall=%b, required 4/6/0", cyc, lo, stall);
    end
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != 4 || lo !== 32'd35 || hi !== 32'd0) begin
      errors++;
      $display("FAIL b2b_second: cyc=%0d hi=%h lo=%h, required 4/0/35", cyc, hi, lo);
    end
  endtask

  task automatic test_mt_and_cancel();
    int seen;
    @(negedge clk);
    mtHi = 1'b1; mtData = 32'h12;
    @(negedge clk);
    mtHi = 1'b0; mtLo = 1'b1; mtData = 32'h34;
    start = 1'b1; isDiv = 1'b0; opA = 32'd9; opB = 32'd9;
    @(negedge clk);
    mtLo = 1'b0; start = 1'b0;
    checks++;
    if (hi !== 32'h12 || lo !== 32'h34 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mt_write: hi=%h lo=%h busy=%b, required 12/34/0", hi, lo, busy);
    end
    start = 1'b1; isDiv = 1'b1; isUnsigned = 1'b0; opA = 32'd1000; opB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h12 || lo !== 32'h34) begin
      errors++;
      $display("FAIL cancel: busy=%b hi=%h lo=%h, required 0/12/34", busy, hi, lo);
    end
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || hi !== 32'h12) begin
      errors++; $display("FAIL cancel_done: pulses=%0d hi=%h, required 0/12", seen, hi);
    end
    // cancel beats start in IDLE
    start = 1'b1; cancel = 1'b1; isDiv = 1'b0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cancel_start: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    start = 1'b1; isDiv = 1'b0; isUnsigned = 1'b1; opA = 32'd3; opB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({hi, lo, busy, stall, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_mul: hi=%h lo=%h busy=%b stall=%b done=%b, required zero",
               hi, lo, busy, stall, done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (lo !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_discard: lo=%h busy=%b, required 0/0", lo, busy);
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_mult_signed();
    test_multu();
    test_div("div_neg7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    test_div("divu_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
    test_div("divu_zero", 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
    test_div("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    test_div("div_7_neg2", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    test_stall_hilo();
    test_back_to_back();
    test_mt_and_cancel();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
